// File: rtl/tile_board_renderer.sv
// Redraws a 4x4 board of 16x16-pixel tiles to a VGA pixel adapter, one tile at a time.
// Each tile word is fetched from a 2-cycle-latency RAM, latched, then rastered over 256 plot cycles.
module tile_board_renderer #(
    parameter int         X_ORIGIN        = 48,
    parameter int         Y_ORIGIN        = 28,
    parameter logic [2:0] FACEDOWN_COLOUR = 3'b111,
    parameter logic [2:0] CURSOR_COLOUR   = 3'b100
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] rdAddr,
    input  logic [7:0] rdData,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);
    // state | meaning
    // IDLE  | waiting for start
    // ADDR  | present tile index on rdAddr
    // WAIT  | hold rdAddr while the RAM responds
    // LATCH | capture rdData into tileReg
    // DRAW  | 256 plot cycles, raster px fastest
    // DONE  | one-cycle done pulse
    typedef enum logic [2:0] {IDLE, ADDR, WAIT, LATCH, DRAW, DONE} state_t;

    localparam logic [7:0] XORG = 8'(X_ORIGIN);
    localparam logic [6:0] YORG = 7'(Y_ORIGIN);

    state_t     state, nextState;
    logic [3:0] tileCnt;
    logic [7:0] pixCnt;
    logic [7:0] tileReg;
    logic [3:0] px, py;
    logic       border;
    logic       unusedIdBits;

    assign px           = pixCnt[3:0];
    assign py           = pixCnt[7:4];
    assign border       = (px == 4'd0) || (px == 4'd15) || (py == 4'd0) || (py == 4'd15);
    assign unusedIdBits = ^tileReg[7:5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tileCnt <= 4'd0;
            pixCnt  <= 8'd0;
            tileReg <= 8'd0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    tileCnt <= 4'd0;
                    pixCnt  <= 8'd0;
                end
                LATCH: begin
                    tileReg <= rdData;
                    pixCnt  <= 8'd0;
                end
                DRAW: begin
                    pixCnt <= pixCnt + 8'd1;
                    if (pixCnt == 8'd255 && tileCnt != 4'd15) tileCnt <= tileCnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:  if (start) nextState = ADDR;
            ADDR:  nextState = WAIT;
            WAIT:  nextState = LATCH;
            LATCH: nextState = DRAW;
            DRAW:  if (pixCnt == 8'd255) nextState = (tileCnt == 4'd15) ? DONE : ADDR;
            DONE:  nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_comb begin
        rdAddr = 4'd0;
        x      = 8'd0;
        y      = 7'd0;
        colour = 3'd0;
        plot   = 1'b0;
        busy   = (state != IDLE);
        done   = (state == DONE);
        case (state)
            ADDR, WAIT, LATCH: rdAddr = tileCnt;
            DRAW: begin
                plot = 1'b1;
                x    = XORG + {2'b00, tileCnt[1:0], 4'b0000} + {4'b0000, px};
                y    = YORG + {1'b0, tileCnt[3:2], 4'b0000} + {3'b000, py};
                if (tileReg[0] && border) colour = CURSOR_COLOUR;
                else if (tileReg[1])      colour = tileReg[4:2];
                else                      colour = FACEDOWN_COLOUR;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_tile_board_renderer.sv
// Scoreboard bench for tile_board_renderer: a behavioural 2-cycle RAM feeds the DUT and
// every plotted pixel is popped against a model-generated expectation queue.
module tb_tile_board_renderer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [3:0] rdAddr;
    logic [7:0] rdData = 8'd0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, done;

    logic [7:0]  ram [16];
    logic [7:0]  pipe1 = 8'd0;
    bit          toggleEn = 1'b0;
    logic [17:0] expQ [$];

    int checks = 0;
    int errors = 0;
    int plotCnt = 0, doneCnt = 0, busyCnt = 0, cursorCnt = 0;
    logic [14:0] firstPix, lastPix;

    tile_board_renderer dut (
        .clk(clk), .reset(reset), .start(start), .rdAddr(rdAddr), .rdData(rdData),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // RAM with 2-cycle read latency; optional corruption of rdData while plotting
    always @(posedge clk) begin
        pipe1 <= ram[rdAddr];
        if (toggleEn && plot) rdData <= ~rdData;
        else                  rdData <= pipe1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (busy) busyCnt++;
            if (done) doneCnt++;
            if (plot) begin
                if (plotCnt == 0) firstPix = {x, y};
                lastPix = {x, y};
                plotCnt++;
                if (colour == 3'b100) cursorCnt++;
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_plot: got x=%0d y=%0d colour=%0b, expected no plot", x, y, colour);
                end else begin
                    automatic logic [17:0] e = expQ.pop_front();
                    if ({x, y, colour} !== e)
                    begin
                        errors++;
                        $display("FAIL pixel: got x=%0d y=%0d colour=%0b, expected x=%0d y=%0d colour=%0b",
                                 x, y, colour, e[17:10], e[9:3], e[2:0]);
                    end
                end
            end
        end
    end

    task automatic push_redraw();
        for (int t = 0; t < 16; t++) begin
            automatic logic [7:0] w = ram[t];
            for (int py = 0; py < 16; py++) begin
                for (int px = 0; px < 16; px++) begin
                    automatic logic [7:0] ex = 8'(48 + 16 * (t % 4) + px);
                    automatic logic [6:0] ey = 7'(28 + 16 * (t / 4) + py);
                    automatic logic [2:0] ec;
                    automatic bit onBorder = (px == 0) || (px == 15) || (py == 0) || (py == 15);
                    if (w[0] && onBorder) ec = 3'b100;
                    else if (w[1])        ec = w[4:2];
                    else                  ec = 3'b111;
                    expQ.push_back({ex, ey, ec});
                end
            end
        end
    endtask

    task automatic clear_stats();
        plotCnt = 0; doneCnt = 0; busyCnt = 0; cursorCnt = 0;
    endtask

    task automatic clear_ram();
        for (int i = 0; i < 16; i++) ram[i] = 8'h00;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (doneCnt >= target) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++;
        if ({rdAddr, x, y, colour, plot, busy, done} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got rdAddr=%0d x=%0d y=%0d colour=%0b plot=%0b busy=%0b done=%0b, expected all 0",
                     rdAddr, x, y, colour, plot, busy, done);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%0b, expected 0", busy);
        end
    endtask

    task automatic test_facedown();
        bit ok;
        clear_ram();
        clear_stats();
        push_redraw();
        pulse_start();
        wait_done(1, 6000, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok) begin errors++; $display("FAIL facedown_timeout: got no done, expected done within 6000 cycles"); end
        checks++;
        if (plotCnt != 4096) begin errors++; $display("FAIL facedown_plots: got %0d, expected 4096", plotCnt); end
        checks++;
        if (doneCnt != 1) begin errors++; $display("FAIL facedown_done: got %0d, expected 1", doneCnt); end
        checks++;
        if (busyCnt != 4145) begin errors++; $display("FAIL facedown_busy: got %0d, expected 4145", busyCnt); end
        checks++;
        if (firstPix !== {8'd48, 7'd28}) begin
            errors++; $display("FAIL first_pixel: got (%0d,%0d), expected (48,28)", firstPix[14:7], firstPix[6:0]);
        end
        checks++;
        if (lastPix !== {8'd111, 7'd91}) begin
            errors++; $display("FAIL last_pixel: got (%0d,%0d), expected (111,91)", lastPix[14:7], lastPix[6:0]);
        end
        checks++;
        if (expQ.size() != 0) begin errors++; $display("FAIL facedown_leftover: got %0d, expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_faceup_tile();
        bit ok;
        clear_ram();
        ram[5] = 8'b000011_10;
        clear_stats();
        push_redraw();
        pulse_start();
        wait_done(1, 6000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || plotCnt != 4096) begin
            errors++; $display("FAIL faceup_plots: got %0d (done=%0b), expected 4096", plotCnt, ok);
        end
        checks++;
        if (expQ.size() != 0) begin errors++; $display("FAIL faceup_leftover: got %0d, expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_cursor();
        bit ok;
        clear_ram();
        ram[0] = 8'h01;
        clear_stats();
        push_redraw();
        pulse_start();
        wait_done(1, 6000, ok);
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || cursorCnt != 60) begin
            errors++; $display("FAIL cursor_border: got %0d cursor pixels (done=%0b), expected 60", cursorCnt, ok);
        end
        checks++;
        if (expQ.size() != 0) begin errors++; $display("FAIL cursor_leftover: got %0d, expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_restart_ignored();
        bit ok;
        clear_ram();
        ram[9] = 8'b000110_10;
        clear_stats();
        push_redraw();
        pulse_start();
        repeat (1000) @(negedge clk);
        pulse_start();
        wait_done(1, 6000, ok);
        repeat (20) @(negedge clk);
        checks++;
        if (plotCnt != 4096) begin errors++; $display("FAIL restart_plots: got %0d, expected 4096", plotCnt); end
        checks++;
        if (doneCnt != 1) begin errors++; $display("FAIL restart_done: got %0d, expected 1", doneCnt); end
        expQ.delete();
    endtask

    task automatic test_rddata_toggle();
        bit ok;
        clear_ram();
        ram[2] = 8'b000101_10;
        clear_stats();
        push_redraw();
        toggleEn = 1'b1;
        pulse_start();
        wait_done(1, 6000, ok);
        toggleEn = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (!ok || plotCnt != 4096) begin
            errors++; $display("FAIL toggle_plots: got %0d (done=%0b), expected 4096", plotCnt, ok);
        end
        checks++;
        if (expQ.size() != 0) begin errors++; $display("FAIL toggle_leftover: got %0d, expected 0", expQ.size()); end
        expQ.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_ram();
        ram[15] = 8'b000111_11;
        clear_stats();
        push_redraw();
        push_redraw();
        @(negedge clk);
        start = 1'b1;
        wait_done(1, 6000, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL b2b_first_timeout: got no done, expected done within 6000 cycles"); end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: got busy=%0b, expected 0", busy); end
        @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL b2b_retrigger: got busy=%0b, expected 1", busy); end
        start = 1'b0;
        wait_done(2, 6000, ok);
        repeat (3) @(negedge clk);
        checks++;
        if (!ok || doneCnt != 2) begin errors++; $display("FAIL b2b_done: got %0d, expected 2", doneCnt); end
        checks++;
        if (plotCnt != 8192) begin errors++; $display("FAIL b2b_plots: got %0d, expected 8192", plotCnt); end
        expQ.delete();
    endtask

    task automatic test_reset_mid_draw();
        bit found = 1'b0;
        clear_ram();
        clear_stats();
        push_redraw();
        pulse_start();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            #1;
            if (plot && x == 8'd96 && y == 7'd44) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin errors++; $display("FAIL tile7_reach: got no tile 7 pixel, expected one within 6000 cycles"); end
        repeat (10) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({rdAddr, x, y, colour, plot, busy, done} !== 25'd0) begin
            errors++;
            $display("FAIL mid_reset_outputs: got rdAddr=%0d x=%0d y=%0d colour=%0b plot=%0b busy=%0b done=%0b, expected all 0",
                     rdAddr, x, y, colour, plot, busy, done);
        end
        expQ.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        clear_stats();
        repeat (1000) @(negedge clk);
        #1;
        checks++;
        if (plotCnt != 0 || busyCnt != 0) begin
            errors++; $display("FAIL post_reset_idle: got plots=%0d busy=%0d, expected 0 and 0", plotCnt, busyCnt);
        end
    endtask

    initial begin
        clear_ram();
        test_reset();
        test_facedown();
        test_faceup_tile();
        test_cursor();
        test_restart_ignored();
        test_rddata_toggle();
        test_back_to_back();
        test_reset_mid_draw();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
